tt_um_kharar_uart_tx: RTL
=========================

TT_UM_KHARAR_UART_TX -- requirements
Module: tt_um_kharar_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit (legal range 2..255).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, byte FIFO entries (power of two).
REQ-003 The block SHALL have port clk, input, 1, the single clock.
REQ-004 The block SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-005 The block SHALL have port ena, input, 1, design selected; while low, no pushes are accepted.
REQ-006 The block SHALL have port ui_in, input, 8, byte to transmit.
REQ-007 The block SHALL have port uio_in, input, 8; bit0 = wr_valid; other bits ignored.
REQ-008 The block SHALL have port uo_out, output, 8: bit0 tx, bit1 busy, bit2 fifo_empty, bit3 fifo_full, bits6:4 count, bit7 overflow.
REQ-009 The block SHALL have port uio_out, output, 8: bit1 wr_ready; all other bits 0.
REQ-010 The block SHALL have port uio_oe, output, 8, constant 8'b0000_0010.

Function
REQ-011 Push SHALL occur on a rising clk edge where wr_valid=1, wr_ready=1 and ena=1; ui_in is written at the write pointer.
REQ-012 wr_ready SHALL equal ena AND NOT fifo_full, computed from registered state only, so a same-cycle pop does not admit a push into a full FIFO.
REQ-013 Pointers SHALL be log2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH; count SHALL be 0..FIFO_DEPTH, +1 on push, -1 on pop, unchanged on simultaneous push and pop.
REQ-014 overflow SHALL set when wr_valid=1 and ena=1 and fifo_full=1, and SHALL stay sticky until reset.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY (when enabled), STOP.
REQ-016 IDLE: tx=1; if FIFO not empty, pop the head into the shift register and go to START on that edge.
REQ-017 START: tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-018 DATA: 8 bits LSB first, each CLKS_PER_BIT cycles; after bit 7 go to PARITY or STOP.
REQ-019 STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE; a queued byte is popped on the next edge, giving exactly one IDLE cycle between frames.
REQ-020 Latency: a byte pushed at edge N into an empty FIFO with FSM IDLE SHALL drive tx=0 from edge N+2.
REQ-021 tx SHALL be a registered output, glitch-free; busy=1 in every state except IDLE.
REQ-022 ena low SHALL NOT abort a frame in progress; queued bytes still drain.

Reset
REQ-023 While rst_n=0 the block SHALL hold: tx=1, busy=0, fifo_empty=1, fifo_full=0, count=0, overflow=0, FSM IDLE, pointers 0, bit counter 0, baud counter 0.
REQ-024 Reset asserted mid-frame SHALL immediately force tx=1 and discard the FIFO contents and the shift register.

Configuration
REQ-025 Macro KHARAR_UART_PARITY_EN defined: the PARITY state SHALL be inserted after DATA, sending the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles, giving an 11-bit frame.
REQ-026 Macro KHARAR_UART_PARITY_EN absent: no PARITY state or logic; DATA goes to STOP, giving a 10-bit frame.

Structure
REQ-027 Package kharar_uart_pkg SHALL hold the FSM state enum type, the frame-bit constants (START_BIT=0, STOP_BIT=1) and the data width constant 8.
REQ-028 The FIFO SHALL be the sub-module kharar_byte_fifo (push, pop, data, full, empty, count); the FSM, baud counter and pin mapping stay in the top module.

Verification
REQ-029 Single byte: reset, push 0x55 with defaults -> tx=0 from edge N+2, then bits 1,0,1,0,1,0,1,0 at 16 cycles each, stop=1; frame lasts 160 cycles, busy deasserts after it.
REQ-030 Back-to-back: push 0x00, 0xFF, 0xA5, 0x3C on consecutive cycles -> count reaches 3 after the first pop, all four frames are sent in order, and each STOP is followed by exactly one IDLE cycle.
REQ-031 Full/overflow: with busy, push 5 bytes -> fifo_full=1, wr_ready=0 after the FIFO fills, overflow=1 on the rejected push, and the fifth byte is never sent.
REQ-032 Reset mid-frame: assert rst_n=0 during DATA bit 3 of 0xF0 -> tx=1 immediately, count=0, and no resumed frame after release.
REQ-033 ena gating: ena=0 with wr_valid=1 and 0x12 -> no push, overflow=0; drop ena during a frame -> the frame still completes.
REQ-034 Parity build: with KHARAR_UART_PARITY_EN, byte 0x07 -> parity bit 1 and an 11-bit frame (176 cycles).

Source files
------------

// File: rtl/kharar_uart_pkg.sv
// Shared types and constants for the kharar UART transmitter.
// Optional feature macro: KHARAR_UART_PARITY_EN (adds an even-parity bit per frame).
package kharar_uart_pkg;

  // Width of one transmitted character.
  localparam int DATA_W = 8;

  // Width of the index that walks through the data bits.
  localparam int BIT_IDX_W = $clog2(DATA_W);

  // Line levels for the framing bits.
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Transmit FSM states. PARITY exists only in the parity build.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef KHARAR_UART_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_t;

  // Even parity: the XOR of all data bits, so that data plus parity has an even number of ones.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/kharar_byte_fifo.sv
// Byte FIFO feeding the UART transmitter.
// DEPTH must be a power of two so the pointers wrap naturally. The head entry is
// presented combinationally on rd_data so a pop can load it on the same edge.
// full/empty are decoded from the registered occupancy count only.
module kharar_byte_fifo
  import kharar_uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wr_data,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Never write into a full FIFO or read from an empty one, whatever the caller does.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Storage array; contents are meaningless while empty, so it is not reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tt_um_kharar_uart_tx.sv
// Tiny Tapeout wrapper: FIFO-buffered UART transmitter (8 data bits, 1 stop bit).
// Optional feature macro: KHARAR_UART_PARITY_EN inserts an even-parity bit after
// the data bits, giving an 11-bit frame instead of 10.
//
// Pin map:
//   uio_in[0]  wr_valid
//   uo_out     {overflow, count[2:0], fifo_full, fifo_empty, busy, tx}
//   uio_out[1] wr_ready (the only driven bidirectional pin)
//
// tx is registered from the current FSM state, so the line lags the state by one
// cycle: a byte pushed at edge N is popped at N+1 (state -> START) and the start
// bit appears on tx from edge N+2. Every bit still lasts exactly CLKS_PER_BIT cycles.
module tt_um_kharar_uart_tx
  import kharar_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int         CW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_W - 1);

  // Input side
  logic              wr_valid;
  logic              wr_ready;
  logic              push;
  logic              overflow;

  // FIFO side
  logic              pop;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [2:0]        count_field;

  // Transmit FSM
  uart_state_t          state;
  logic [7:0]           baud_cnt;
  logic [BIT_IDX_W-1:0] bit_idx;
  logic [DATA_W-1:0]    shift;
  logic                 tx;
  logic                 busy;
  logic                 bit_done;
`ifdef KHARAR_UART_PARITY_EN
  logic                 parity;
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, uio_in[7:1]};

  assign wr_valid = uio_in[0];

  // Readiness comes only from registered FIFO state, so a pop in the same cycle
  // cannot open a slot for a push while the FIFO reads full.
  assign wr_ready = ena && !fifo_full;
  assign push     = wr_valid && wr_ready;

  // The FSM takes the head byte whenever it is idle and data is waiting.
  assign pop      = (state == ST_IDLE) && !fifo_empty;

  assign bit_done = (baud_cnt == BAUD_LAST);

  kharar_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (ui_in),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Sticky flag: a write was attempted while enabled and the FIFO was full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (wr_valid && ena && fifo_full) begin
      overflow <= 1'b1;
    end
  end

  // Frame sequencer: baud timing, bit walking and the registered tx/busy outputs.
  // ena is deliberately not looked at here so a frame in flight always completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= STOP_BIT;
      busy     <= 1'b0;
`ifdef KHARAR_UART_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          tx <= STOP_BIT;
          if (!fifo_empty) begin
            shift    <= fifo_data;
`ifdef KHARAR_UART_PARITY_EN
            parity   <= even_parity(fifo_data);
`endif
            baud_cnt <= '0;
            bit_idx  <= '0;
            busy     <= 1'b1;
            state    <= ST_START;
          end
        end

        ST_START: begin
          tx <= START_BIT;
          if (bit_done) begin
            baud_cnt <= '0;
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 8'd1;
          end
        end

        ST_DATA: begin
          // LSB first: the current bit always sits in shift[0].
          tx <= shift[0];
          if (bit_done) begin
            baud_cnt <= '0;
            shift    <= shift >> 1;
            if (bit_idx == LAST_BIT) begin
              bit_idx <= '0;
`ifdef KHARAR_UART_PARITY_EN
              state   <= ST_PARITY;
`else
              state   <= ST_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + BIT_IDX_W'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + 8'd1;
          end
        end

`ifdef KHARAR_UART_PARITY_EN
        ST_PARITY: begin
          tx <= parity;
          if (bit_done) begin
            baud_cnt <= '0;
            state    <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt + 8'd1;
          end
        end
`endif

        ST_STOP: begin
          tx <= STOP_BIT;
          if (bit_done) begin
            // Returning to IDLE costs one cycle before the next byte is popped.
            baud_cnt <= '0;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 8'd1;
          end
        end

        default: begin
          tx       <= STOP_BIT;
          busy     <= 1'b0;
          baud_cnt <= '0;
          bit_idx  <= '0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  // Occupancy is shown on three pins; deeper FIFOs report the low bits.
  assign count_field = 3'(fifo_count);

  assign uo_out  = {overflow, count_field, fifo_full, fifo_empty, busy, tx};
  assign uio_out = {6'b0, wr_ready, 1'b0};
  assign uio_oe  = 8'b0000_0010;

endmodule
